mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the CPU's instruction-fetch port (read-only) and its load/store data port.
- Sits between the core and the memory inside Computer.
- Data requests normally win; a streak limit stops data traffic from starving fetch.
- A timeout terminates any memory access that is never acknowledged and flags it as an error.

---
 rtl/mem_bus_pkg.sv | 24 ++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
`default_nettype none
// mem_bus_pkg: shared bus widths, arbiter state encoding and the core-side request record.
// Revision: 1.0
package mem_bus_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int STRB_WIDTH     = DEF_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                      we;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0]     wstrb;
  } bus_req_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: shares one single-port memory between instruction fetch and load/store, with data priority, a fetch anti-starvation streak limit and an ack timeout.
// Revision: 1.0
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_valid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_err,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic                    d_valid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack
);

  localparam int              SW         = $clog2(MAX_D_STREAK + 1);
  localparam int              TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [TW-1:0]   T_LAST     = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  arb_state_t    state;
  logic [SW-1:0] streak;
  logic [TW-1:0] tcnt;

  logic if_elig;
  logic d_elig;
  logic grant_i;
  logic grant_d;
  logic timed_out;

  // A request seen during its own valid cycle is the tail of the finished transfer.
  always_comb begin
    if_elig = if_req && !if_valid;
    d_elig  = d_req && !d_valid;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (if_elig && d_elig) begin
        if (streak == STREAK_MAX) grant_i = 1'b1;
        else                      grant_d = 1'b1;
      end else begin
        grant_i = if_elig;
        grant_d = d_elig;
      end
    end
  end

  assign timed_out = TIMEOUT_EN && !mem_ack && (tcnt == T_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      streak    <= '0;
      tcnt      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      d_valid   <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      if_err   <= 1'b0;
      d_valid  <= 1'b0;
      d_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i) begin
            state     <= BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            tcnt      <= '0;
          end else if (grant_d) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wstrb <= d_we ? d_wstrb : '0;
            tcnt      <= '0;
          end
          if (grant_i || !if_req)
            streak <= '0;
          else if (grant_d && if_elig && streak != STREAK_MAX)
            streak <= streak + SW'(1);
        end
        BUSY_I, BUSY_D: begin
          // An ack in the timeout cycle still completes normally.
          if (mem_ack || timed_out) begin
            mem_req <= 1'b0;
            state   <= IDLE;
            if (state == BUSY_I) begin
              if_valid <= 1'b1;
              if_err   <= !mem_ack;
              if_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              d_valid <= 1'b1;
              d_err   <= !mem_ack;
              d_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
// Revision: 1.0
module tb_mem_arbiter;
  import mem_bus_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;
  localparam int TO   = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          if_err;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [3:0]    d_wstrb = '0;
  logic          d_valid;
  logic [DW-1:0] d_rdata;
  logic          d_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  always #5 clock = ~clock;

  mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_D_STREAK(MAXS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int checks = 0;
  int passes = 0;

  // Model: who owns the memory, what was granted, how long it has waited.
  int            owner;        // 0 none, 1 fetch, 2 data
  int            waited;       // cycles the access has gone without an ack
  int            run;          // data grants in a row that made fetch wait
  bus_req_t      cur;
  logic          e_mem_req, e_if_valid, e_if_err, e_d_valid, e_d_err;
  logic [DW-1:0] e_if_rdata, e_d_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    owner = 0; waited = 0; run = 0; cur = '0;
    e_mem_req = 0; e_if_valid = 0; e_if_err = 0; e_d_valid = 0; e_d_err = 0;
    e_if_rdata = '0; e_d_rdata = '0;
  endtask

  task automatic finish_access(input logic err, input logic [DW-1:0] data);
    e_mem_req = 0;
    if (owner == 1) begin e_if_valid = 1; e_if_err = err; e_if_rdata = data; end
    else            begin e_d_valid  = 1; e_d_err  = err; e_d_rdata  = data; end
    owner = 0;
  endtask

  // Predict the outputs after the coming rising edge from the inputs now applied.
  task automatic advance();
    bit fe, de;
    int who;
    if (!reset) begin model_reset(); return; end
    fe = if_req && !e_if_valid;
    de = d_req && !e_d_valid;
    e_if_valid = 0; e_d_valid = 0; e_if_err = 0; e_d_err = 0;
    if (owner == 0) begin
      who = 0;
      if (fe && de)  who = (run >= MAXS) ? 1 : 2;
      else if (fe)   who = 1;
      else if (de)   who = 2;
      if (who == 1 || !if_req)   run = 0;
      else if (who == 2 && fe)   run = (run < MAXS) ? run + 1 : run;
      if (who == 1) begin
        cur.we = 0; cur.addr = if_addr; cur.wdata = '0; cur.wstrb = '0;
      end else if (who == 2) begin
        cur.we = d_we; cur.addr = d_addr; cur.wdata = d_wdata; cur.wstrb = d_we ? d_wstrb : 4'h0;
      end
      if (who != 0) begin owner = who; waited = 0; e_mem_req = 1; end
    end else if (mem_ack) begin
      finish_access(1'b0, cur.we ? '0 : mem_rdata);
    end else begin
      waited++;
      if (TO > 0 && waited == TO) finish_access(1'b1, '0);
    end
  endtask

  task automatic compare();
    chk("mem_req", mem_req, e_mem_req);
    if (e_mem_req) begin
      chk("mem_we", mem_we, cur.we);
      chk("mem_addr", mem_addr, cur.addr);
      chk("mem_wstrb", mem_wstrb, cur.wstrb);
      if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
    end
    chk("if_valid", if_valid, e_if_valid);
    chk("d_valid", d_valid, e_d_valid);
    if (e_if_valid) begin chk("if_err", if_err, e_if_err); chk("if_rdata", if_rdata, e_if_rdata); end
    if (e_d_valid)  begin chk("d_err", d_err, e_d_err);    chk("d_rdata", d_rdata, e_d_rdata);    end
  endtask

  task automatic cycle();
    advance();
    @(posedge clock);
    @(negedge clock);
    compare();
  endtask

  logic [AW-1:0] grants [0:15];
  int            ngr;
  logic          prev_req;
  int            age, dly;

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_d_rdata", d_rdata, 0);
    reset = 1'b1;
    cycle();

    // 1: single fetch, ack two cycles after mem_req rises
    if_req = 1; if_addr = 32'h100; cycle();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_we", mem_we, 0);
    cycle(); cycle();
    mem_ack = 1; mem_rdata = 32'h0000_0013; cycle();
    mem_ack = 0;
    chk("t1_if_valid", if_valid, 1);
    chk("t1_if_rdata", if_rdata, 32'h13);
    cycle();
    chk("t1_no_reissue", mem_req, 0);
    if_req = 0; cycle();

    // 2: collision, data first then fetch
    d_req = 1; d_we = 0; d_addr = 32'h2000; if_req = 1; if_addr = 32'h104; cycle();
    chk("t2_data_first", mem_addr, 32'h2000);
    mem_ack = 1; mem_rdata = 32'hA5A5_0001; cycle();
    mem_ack = 0;
    chk("t2_d_valid", d_valid, 1);
    d_req = 0; cycle();
    chk("t2_fetch_next", mem_addr, 32'h104);
    chk("t2_fetch_req", mem_req, 1);
    mem_ack = 1; mem_rdata = 32'h0000_0093; cycle();
    mem_ack = 0;
    chk("t2_if_valid", if_valid, 1);
    if_req = 0; cycle(); cycle();

    // 3: data held continuously; its own valid cycle masks it, so fetch takes that slot
    d_req = 1; d_we = 0; d_addr = 32'h2000; if_req = 1; if_addr = 32'h200;
    ngr = 0; prev_req = 0;
    for (int n = 0; n < 24; n++) begin
      cycle();
      if (mem_req && !prev_req && ngr < 16) begin grants[ngr] = mem_addr; ngr++; end
      prev_req = mem_req;
      if (e_d_valid)  d_addr  = d_addr + 4;
      if (e_if_valid) if_addr = if_addr + 4;
      mem_ack = e_mem_req;
    end
    d_req = 0; if_req = 0; mem_ack = 0;
    cycle(); cycle(); cycle();
    chk("t3_ngrants", (ngr >= 4) ? 1 : 0, 1);
    if (ngr >= 4) begin
      chk("t3_g0", grants[0], 32'h2000);
      chk("t3_g1", grants[1], 32'h200);
      chk("t3_g2", grants[2], 32'h2004);
      chk("t3_g3", grants[3], 32'h204);
    end

    // 4: write with partial strobes
    d_req = 1; d_we = 1; d_addr = 32'h3000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011; cycle();
    chk("t4_mem_we", mem_we, 1);
    chk("t4_mem_wstrb", mem_wstrb, 4'b0011);
    chk("t4_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF; cycle();
    mem_ack = 0;
    chk("t4_d_valid", d_valid, 1);
    chk("t4_d_rdata", d_rdata, 0);
    d_req = 0; d_we = 0; cycle();

    // 5a: no ack ever, timeout after 8 cycles of mem_req
    d_req = 1; d_addr = 32'h4000; cycle();
    for (int i = 1; i <= 8; i++) begin
      chk("t5_mem_req_held", mem_req, 1);
      cycle();
    end
    chk("t5_d_valid", d_valid, 1);
    chk("t5_d_err", d_err, 1);
    chk("t5_d_rdata", d_rdata, 0);
    chk("t5_mem_req_drop", mem_req, 0);
    d_req = 0; cycle();
    // 5b: ack in the timeout cycle wins
    d_req = 1; d_addr = 32'h4004; cycle();
    for (int i = 1; i < 8; i++) cycle();
    mem_ack = 1; mem_rdata = 32'h0BAD_F00D; cycle();
    mem_ack = 0;
    chk("t5b_d_valid", d_valid, 1);
    chk("t5b_d_err", d_err, 0);
    chk("t5b_d_rdata", d_rdata, 32'h0BAD_F00D);
    d_req = 0; cycle();

    // 6: asynchronous reset in the middle of a data access
    d_req = 1; d_addr = 32'h5000; cycle(); cycle();
    #2 reset = 0;
    #1 chk("t6_async_drop", mem_req, 0);
    model_reset();
    cycle();
    chk("t6_no_valid", d_valid, 0);
    reset = 1; d_addr = 32'h5004; cycle();
    chk("t6_regrant", mem_req, 1);
    chk("t6_regrant_addr", mem_addr, 32'h5004);
    mem_ack = 1; mem_rdata = 32'h1234_5678; cycle();
    mem_ack = 0; d_req = 0; cycle();

    // Randomized traffic with random ack delays, stray acks and timeouts
    age = 0; dly = 0;
    for (int n = 0; n < 3000; n++) begin
      mem_rdata = $urandom;
      if (!e_mem_req) begin
        age = 0; dly = $urandom_range(0, 10);
        mem_ack = ($urandom_range(0, 7) == 0);
      end else begin
        mem_ack = (age == dly);
        age++;
      end
      if (!if_req || e_if_valid) begin
        if_req = 1'($urandom_range(0, 1));
        if_addr = $urandom;
      end
      if (!d_req || e_d_valid) begin
        d_req = 1'($urandom_range(0, 1));
        d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'($urandom);
      end else if ($urandom_range(0, 3) == 0) begin
        d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'($urandom);
      end
      cycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
